// File: rtl/joy_db15_pkg.sv
// Shared definitions for the DB15 joystick link (responder and host-side reader).
package joy_db15_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Pad word bit positions, active-high in the pad word.
   localparam int unsigned JOY_BIT_R   = 0;
   localparam int unsigned JOY_BIT_L   = 1;
   localparam int unsigned JOY_BIT_D   = 2;
   localparam int unsigned JOY_BIT_U   = 3;
   localparam int unsigned JOY_BIT_BTN = 4;

endpackage

// File: rtl/joy_sync.sv
// Multi-flop synchronizer for an asynchronous host line; resets to 1 so that
// leaving reset never produces a false edge.
module joy_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [STAGES-1:0] sync;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= '1;
      else     sync <= {sync[STAGES-2:0], din};
   end

   assign dout = sync[STAGES-1];

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick link responder: captures two pad words on the host load strobe
// and shifts them out one bit per host clock rising edge, active-low per bit.
// Optional host-activity watchdog: define JOY_DB15_TX_WATCHDOG_EN.
module joy_db15_tx
   import joy_db15_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned PAD_BITS       = 16,
   parameter int unsigned TIMEOUT_CYCLES = 2400000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PAD_BITS-1:0] joystick1,
   input  logic [PAD_BITS-1:0] joystick2,
   input  logic                joy_clk,
   input  logic                joy_load,
   output logic                joy_data,
   output logic                frame_done,
   output logic                link_active
);

   localparam int unsigned FRAME_BITS = 2 * PAD_BITS;
   localparam int unsigned CNT_W      = $clog2(FRAME_BITS) + 1;

   state_t                  state, state_next;
   logic [FRAME_BITS-1:0]   shreg;
   logic [CNT_W-1:0]        bit_cnt;
   logic                    clk_s, load_s, clk_prev, clk_rise;
   logic                    load_en, shift_en, last_shift, clear_en, timeout;

   joy_sync #(.STAGES(SYNC_STAGES)) u_sync_clk  (.clk(clk), .rst(reset), .din(joy_clk),  .dout(clk_s));
   joy_sync #(.STAGES(SYNC_STAGES)) u_sync_load (.clk(clk), .rst(reset), .din(joy_load), .dout(load_s));

   // Previous synced host clock for rising-edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) clk_prev <= 1'b1;
      else       clk_prev <= clk_s;
   end

   assign clk_rise = clk_s & ~clk_prev;

`ifdef JOY_DB15_TX_WATCHDOG_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic            load_prev, load_fall, link_r;
   logic [WD_W-1:0] wd_cnt;

   // Previous synced load for falling-edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) load_prev <= 1'b1;
      else       load_prev <= load_s;
   end

   assign load_fall = load_prev & ~load_s;
   assign timeout   = (wd_cnt == WD_W'(TIMEOUT_CYCLES));

   // Idle-time counter and link status: cleared by each load, saturating at the timeout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_cnt <= '0;
         link_r <= 1'b0;
      end else begin
         if (load_fall)     wd_cnt <= '0;
         else if (!timeout) wd_cnt <= wd_cnt + WD_W'(1);
         if (load_fall)     link_r <= 1'b1;
         else if (timeout)  link_r <= 1'b0;
      end
   end

   assign link_active = link_r;
`else
   assign timeout     = 1'b0;
   assign link_active = 1'b1;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next state and datapath controls; timeout beats load, load beats shift.
   always_comb begin
      state_next = state;
      load_en    = 1'b0;
      shift_en   = 1'b0;
      last_shift = 1'b0;
      clear_en   = 1'b0;
      if (timeout) begin
         state_next = IDLE;
         clear_en   = 1'b1;
      end else if (!load_s) begin
         state_next = LOAD;
         load_en    = 1'b1;
      end else begin
         case (state)
            IDLE:  state_next = IDLE;
            LOAD:  state_next = SHIFT;
            SHIFT: if (clk_rise) begin
                      shift_en = 1'b1;
                      if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                         last_shift = 1'b1;
                         state_next = DONE;
                      end
                   end
            DONE:  shift_en = clk_rise;
            default: state_next = IDLE;
         endcase
      end
   end

   // Shift register, saturating bit counter and frame-done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg      <= '1;
         bit_cnt    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= last_shift;
         if (clear_en) begin
            shreg   <= '1;
            bit_cnt <= '0;
         end else if (load_en) begin
            shreg   <= {~joystick2, ~joystick1};
            bit_cnt <= '0;
         end else if (shift_en) begin
            shreg <= {1'b1, shreg[FRAME_BITS-1:1]};
            if (bit_cnt != CNT_W'(FRAME_BITS)) bit_cnt <= bit_cnt + CNT_W'(1);
         end
      end
   end

   assign joy_data = shreg[0];

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx with a queue of expected serial bits and a
// reference model of the shift chain and frame counter.
module tb_joy_db15_tx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] joystick1 = '0;
   logic [15:0] joystick2 = '0;
   logic        joy_clk = 1'b0;
   logic        joy_load = 1'b1;
   logic        joy_data, frame_done, link_active;

   int          checks = 0;
   int          failures = 0;
   int          fd_seen = 0;
   int          fd_exp = 0;
   logic        exp_q[$];
   logic [31:0] mdl = '1;
   int          mcnt = 32;

   joy_db15_tx #(.SYNC_STAGES(2), .PAD_BITS(16), .TIMEOUT_CYCLES(1000)) dut (
      .clk(clk), .reset(reset), .joystick1(joystick1), .joystick2(joystick2),
      .joy_clk(joy_clk), .joy_load(joy_load), .joy_data(joy_data),
      .frame_done(frame_done), .link_active(link_active)
   );

   always #10 clk = ~clk;

   // Count every cycle that frame_done is high.
   always @(negedge clk) if (frame_done === 1'b1) fd_seen++;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_data(input string tag);
      logic e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s: got %0h expected <scoreboard empty>", tag, joy_data);
      end else begin
         e = exp_q.pop_front();
         chk(tag, {31'd0, joy_data}, {31'd0, e});
      end
   endtask

   task automatic host_load();
      mdl  = {~joystick2, ~joystick1};
      mcnt = 0;
      exp_q.push_back(mdl[0]);
      joy_load = 1'b0;
      cyc(10);
      joy_load = 1'b1;
      cyc(8);
   endtask

   task automatic host_rise();
      if (mcnt == 31) fd_exp++;
      if (mcnt < 32) mcnt++;
      mdl = {1'b1, mdl[31:1]};
      exp_q.push_back(mdl[0]);
      joy_clk = 1'b1;
      cyc(8);
      joy_clk = 1'b0;
      cyc(8);
   endtask

   initial begin
      // Reset state
      cyc(3);
      chk("rst_data", {31'd0, joy_data}, 32'd1);
      chk("rst_done", {31'd0, frame_done}, 32'd0);
`ifdef JOY_DB15_TX_WATCHDOG_EN
      chk("rst_link", {31'd0, link_active}, 32'd0);
`else
      chk("rst_link", {31'd0, link_active}, 32'd1);
`endif
      reset = 1'b0;
      cyc(5);
      chk("idle_data", {31'd0, joy_data}, 32'd1);

      // Full frame, then 8 extra rises with fill ones
      joystick1 = 16'h0001;
      joystick2 = 16'h8000;
      host_load();
      check_data("f1_bit0");
      chk("f1_link", {31'd0, link_active}, 32'd1);
      for (int i = 1; i < 32; i++) begin
         host_rise();
         check_data($sformatf("f1_bit%0d", i));
      end
      chk("f1_nodone_yet", fd_seen, fd_exp);
      for (int i = 32; i < 40; i++) begin
         host_rise();
         check_data($sformatf("f1_fill%0d", i));
         chk($sformatf("f1_done%0d", i), fd_seen, fd_exp);
      end
      chk("f1_done_once", fd_seen, 1);
      chk("f1_bitcnt_sat", {26'd0, dut.bit_cnt}, 32'd32);

      // Aborted frame; pad change during shift is ignored until the reload
      joystick1 = 16'h0001;
      joystick2 = 16'h0000;
      host_load();
      check_data("ab_bit0");
      for (int i = 1; i <= 7; i++) begin
         host_rise();
         if (i == 3) joystick1 = 16'h0004;
         check_data($sformatf("ab_bit%0d", i));
      end
      host_load();
      for (int i = 0; i < 3; i++) begin
         check_data($sformatf("rl_bit%0d", i));
         if (i < 2) host_rise();
      end
      chk("ab_no_done", fd_seen, fd_exp);

      // Host clock rise and load fall in the same cycle: load wins
      joystick1 = 16'h0002;
      mdl  = {~joystick2, ~joystick1};
      mcnt = 0;
      exp_q.push_back(mdl[0]);
      joy_clk  = 1'b1;
      joy_load = 1'b0;
      cyc(10);
      joy_load = 1'b1;
      cyc(8);
      joy_clk = 1'b0;
      cyc(8);
      check_data("sim_bit0");
      host_rise();
      check_data("sim_bit1");

      // Reset mid-frame
      joystick1 = 16'h1234;
      joystick2 = 16'hABCD;
      host_load();
      check_data("rm_bit0");
      for (int i = 1; i <= 12; i++) begin
         host_rise();
         check_data($sformatf("rm_bit%0d", i));
      end
      reset = 1'b1;
      cyc(3);
      chk("rm_rst_data", {31'd0, joy_data}, 32'd1);
      chk("rm_rst_done", {31'd0, frame_done}, 32'd0);
      reset = 1'b0;
      mdl  = '1;
      mcnt = 32;
      exp_q.delete();
      cyc(5);
      host_rise();
      check_data("rm_idle_rise");
      chk("rm_no_done", fd_seen, fd_exp);

      // Fresh load after reset; output holds with no host clocks
      host_load();
      check_data("hold_bit0");
      exp_q.push_back(mdl[0]);
      cyc(100);
      check_data("hold_bit0_later");
      host_rise();
      check_data("hold_bit1");

`ifdef JOY_DB15_TX_WATCHDOG_EN
      // Watchdog expiry, then recovery on the next load
      cyc(1100);
      chk("wd_link_low", {31'd0, link_active}, 32'd0);
      chk("wd_data_high", {31'd0, joy_data}, 32'd1);
      joystick1 = 16'h0001;
      joystick2 = 16'h8000;
      host_load();
      chk("wd_link_high", {31'd0, link_active}, 32'd1);
      check_data("wd_bit0");
      for (int i = 1; i < 32; i++) begin
         host_rise();
         check_data($sformatf("wd_bit%0d", i));
      end
      chk("wd_done", fd_seen, fd_exp);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
